// File: rtl/data_memory_hs_pkg.sv
// Shared encodings and the access-error rule for the handshaked data memory.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Reserved size, misalignment for the access size, or an address past the array.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [1:0] addr_lo,
                                      input logic       out_of_range);
    logic e;
    e = out_of_range;
    case (size)
      SIZE_BYTE: ;
      SIZE_HALF: if (addr_lo[0]) e = 1'b1;
      SIZE_WORD: if (addr_lo != 2'b00) e = 1'b1;
      default:   e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/data_memory_hs_mem_align.sv
// Lane steering: merges store data into the addressed word and extends load data.
module mem_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [3:0]  lane_en,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    lane_en    = 4'b0000;
    store_word = old_word;
    load_data  = 32'd0;
    byte_sel   = old_word[8*addr_lo +: 8];
    half_sel   = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    case (size)
      SIZE_BYTE: begin
        lane_en                     = 4'b0001 << addr_lo;
        store_word[8*addr_lo +: 8]  = wdata[7:0];
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        if (addr_lo[1]) begin
          lane_en           = 4'b1100;
          store_word[31:16] = wdata[15:0];
        end else begin
          lane_en           = 4'b0011;
          store_word[15:0]  = wdata[15:0];
        end
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      SIZE_WORD: begin
        lane_en    = 4'b1111;
        store_word = wdata;
        load_data  = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// Data memory with valid/ready request/response handshake, wait states and
// byte/half/word accesses.
//
//   state | meaning
//   IDLE  | ready for a request; accept captures all request fields
//   WAIT  | counting down configured wait states
//   RESP  | response presented until the consumer takes it
module data_memory_hs
  import data_mem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          ADDR_W      = 32,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] INIT_WORD0  = 32'd5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic              cap_write, cap_unsigned;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;

  logic              acc_write, acc_unsigned;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;

  logic [IDX_W-1:0] idx;
  logic             high_bits, out_of_range, err, enter_resp;
  logic [31:0]      old_word, store_word, load_data;
  logic [3:0]       lane_en;

  logic [31:0] mem [DEPTH] = '{0: INIT_WORD0, default: 32'd0};

  // With no wait states the commit edge is the accept edge, so use the live request.
  assign acc_write    = (state == IDLE) ? req_write    : cap_write;
  assign acc_unsigned = (state == IDLE) ? req_unsigned : cap_unsigned;
  assign acc_size     = (state == IDLE) ? req_size     : cap_size;
  assign acc_addr     = (state == IDLE) ? req_addr     : cap_addr;
  assign acc_wdata    = (state == IDLE) ? req_wdata    : cap_wdata;

  assign idx = acc_addr[IDX_W+1:2];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_hi
      assign high_bits = |acc_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_hi
      assign high_bits = 1'b0;
    end
  endgenerate

  assign out_of_range = high_bits || (32'(idx) >= 32'(DEPTH));
  assign err          = access_err(acc_size, acc_addr[1:0], out_of_range);
  assign old_word     = out_of_range ? 32'd0 : mem[idx];

  mem_align u_align (
    .size        (acc_size),
    .is_unsigned (acc_unsigned),
    .addr_lo     (acc_addr[1:0]),
    .old_word    (old_word),
    .wdata       (acc_wdata),
    .store_word  (store_word),
    .lane_en     (lane_en),
    .load_data   (load_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_write    <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= 2'b00;
      cap_addr     <= '0;
      cap_wdata    <= 32'd0;
    end else if (state == IDLE && req_valid) begin
      cap_write    <= req_write;
      cap_unsigned <= req_unsigned;
      cap_size     <= req_size;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= err;
      resp_rdata <= (err || acc_write) ? 32'd0 : load_data;
    end else if (state == RESP && resp_ready) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  // Array contents survive reset; only lanes selected by the access are written.
  always_ff @(posedge clock) begin
    if (enter_resp && acc_write && !err) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l]) mem[idx][8*l +: 8] <= store_word[8*l +: 8];
      end
    end
  end

endmodule
